// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath select, enable and ALU code.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               memready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [3:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMRD    = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWR    = STATE_W'(5),
    EXECUTE  = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    ADDIEXEC = STATE_W'(9),
    ADDIWB   = STATE_W'(10),
    JUMP     = STATE_W'(11)
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_e state_q, state_d;

  // Returns {supported, alu code}; unsupported functs fall back to add.
  function automatic logic [4:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: decode_funct = {1'b1, ALU_ADD};
      6'b100010: decode_funct = {1'b1, ALU_SUB};
      6'b100100: decode_funct = {1'b1, ALU_AND};
      6'b100101: decode_funct = {1'b1, ALU_OR};
      6'b101010: decode_funct = {1'b1, ALU_SLT};
      default:   decode_funct = {1'b0, ALU_ADD};
    endcase
  endfunction

  logic [4:0] funct_dec;
  assign funct_dec = decode_funct(funct);
  assign state     = state_q;

  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = EXECUTE;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDIEXEC;
          OP_J:           state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_dec[3:0];
        illegal    = ~funct_dec[4];
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = funct_dec[4];
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and writeback over several cycles, sharing one ALU and one unified instruction/data memory. It waits on a memory-ready handshake and generates every datapath mux select, write enable and ALU control code. It decodes lw, sw, R-type, beq, bne, addi and j; any other opcode is flagged illegal.

Parameters:
STATE_W, 4, width of state register and debug state port

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces FETCH
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag (combinational, current cycle)
memready  input  1  memory completes current access this cycle
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  load instruction register
regdst  output  1  write-register select: 0=rt, 1=rd
memtoreg  output  1  writeback data select: 0=ALUOut, 1=data register
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0=PC, 1=register A
alusrcb  output  2  ALU B select: 00=B, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
pcen  output  1  PC write enable
alucontrol  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
illegal  output  1  one-cycle pulse on unsupported opcode
state  output  STATE_W  current state, for debug and verification

Behaviour:
- States (encoding fixed): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Outputs are combinational from state, op, funct, zero and memready. Every output not listed for a state is 0. alucontrol defaults to add.
- While reset=1, memwrite, irwrite, regwrite, pcen and illegal are forced to 0. The state register loads FETCH on the next edge, including mid-instruction. No other storage exists.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=pcen=memready. Stay in FETCH while memready=0; go to DECODE when memready=1.
- DECODE: alusrca=0, alusrcb=11, add (precompute branch target).
  - op 100011 or 101011 -> MEMADR
  - op 000000 -> EXECUTE
  - op 000100 or 000101 -> BRANCH
  - op 001000 -> ADDIEXEC
  - op 000010 -> JUMP
  - any other op -> illegal=1 this cycle, then FETCH
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1. memwrite stays asserted with the address stable until memready=1, then go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - other funct -> add, plus illegal=1 this cycle
  - next state ALUWB in all cases
- ALUWB: regdst=1, memtoreg=0. regwrite=1 unless funct is unsupported (then regwrite=0). Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen=zero for beq (000100), pcen=~zero for bne (000101). Next state FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcen=1. Next state FETCH.
- Latency with memready tied to 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, bne, j 3 cycles
  - each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- An instruction whose op/funct changes mid-sequence is not supported. The instruction register only changes when irwrite=1.

Test Plan:
- Reset, then memready=1, op=100011: state sequence 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. pcen=1 only in the FETCH cycle.
- op=000000, funct=101010, memready=1: states 0,1,6,7,0. alucontrol=0111 in EXECUTE. ALUWB has regwrite=1, regdst=1.
- op=000100, zero=1 then op=000101, zero=1: in BRANCH, pcen=1 with pcsrc=01 for beq; pcen=0 for bne. Both instructions take 3 cycles.
- op=101011, memready held 0 for 3 cycles in FETCH and 2 cycles in MEMWR: FETCH persists 4 cycles with irwrite=0 until the ready cycle. memwrite=1 with iord=1 stays held 3 cycles. Total instruction takes 9 cycles.
- op=111111: illegal=1 for exactly one cycle in DECODE, regwrite=memwrite=0 throughout, then FETCH. op=000000 with funct=000000: illegal pulses in EXECUTE and ALUWB has regwrite=0.
- reset=1 asserted in MEMWR with memready=0: memwrite=0 immediately. State becomes 0 on the next edge, and the following fetch proceeds normally.
